// File: rtl/operand_hazard_ctrl_pkg.sv
// operand_hazard_ctrl_pkg: register-index width, forward-select codes and multi-cycle timer states
package operand_hazard_ctrl_pkg;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int FWD_SEL_W = 2;
  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_SEL_REG = 2'b00;
  localparam fwd_sel_t FWD_SEL_EX = 2'b01;
  localparam fwd_sel_t FWD_SEL_MEM = 2'b10;
  typedef enum logic {MC_IDLE, MC_BUSY} mc_state_e;
  function automatic fwd_sel_t fwd_pick(input logic ex_hit, input logic mem_hit);
    return ex_hit ? FWD_SEL_EX : mem_hit ? FWD_SEL_MEM : FWD_SEL_REG;
  endfunction
endpackage

// File: rtl/operand_hazard_ctrl_if.sv
// operand_hazard_ctrl_if: ID-stage operand info in, stall/bubble/forward controls out
interface operand_hazard_ctrl_if #(
  parameter int REG_ADDR_W = operand_hazard_ctrl_pkg::REG_ADDR_W_DEF,
  parameter int PERF_W = 32
);
  import operand_hazard_ctrl_pkg::*;
  logic id_valid, id_rs_read, id_rt_read, id_wb_en, id_is_load, id_multi_cycle;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_wb_reg;
  logic mem_stall_req, flush;
  logic stall_front, bubble_ex, stall_back, mc_busy;
  fwd_sel_t fwd_sel_1, fwd_sel_2;
  logic [PERF_W-1:0] perf_stall_cnt;
  modport master (
    output id_valid, id_rs_read, id_rs, id_rt_read, id_rt, id_wb_en, id_wb_reg, id_is_load,
           id_multi_cycle, mem_stall_req, flush,
    input stall_front, bubble_ex, stall_back, fwd_sel_1, fwd_sel_2, mc_busy, perf_stall_cnt
  );
  modport slave (
    input id_valid, id_rs_read, id_rs, id_rt_read, id_rt, id_wb_en, id_wb_reg, id_is_load,
          id_multi_cycle, mem_stall_req, flush,
    output stall_front, bubble_ex, stall_back, fwd_sel_1, fwd_sel_2, mc_busy, perf_stall_cnt
  );
endinterface

// File: rtl/operand_hazard_ctrl_mc_stall_timer.sv
// operand_hazard_ctrl_mc_stall_timer: holds busy for CYCLES-1 unpaused cycles after start
module operand_hazard_ctrl_mc_stall_timer
  import operand_hazard_ctrl_pkg::*;
#(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pause,
  input  logic abort,
  output logic busy
);
  localparam int CW = $clog2(CYCLES);
  mc_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // state and remaining-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // start loads the count, pause holds it, abort or the last count returns to idle
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (abort) begin
      state_nxt = MC_IDLE;
      cnt_nxt = '0;
    end else if (state == MC_IDLE) begin
      if (start) begin
        state_nxt = MC_BUSY;
        cnt_nxt = CW'(CYCLES - 2);
      end
    end else if (!pause) begin
      if (cnt == '0) state_nxt = MC_IDLE;
      else cnt_nxt = cnt - 1'b1;
    end
  end
  assign busy = state == MC_BUSY;
endmodule

// File: rtl/operand_hazard_ctrl.sv
// operand_hazard_ctrl: ID operand forwarding and pipeline stall/bubble arbitration (HAZARD_PERF_EN adds stall counter)
module operand_hazard_ctrl
  import operand_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MC_CYCLES = 4,
  parameter int PERF_W = 32
) (
  input logic clk,
  input logic rst,
  operand_hazard_ctrl_if.slave hz
);
  logic ex_v, ex_wb, ex_load, mem_v, mem_wb;
  logic [REG_ADDR_W-1:0] ex_reg, mem_reg;
  logic busy, ex_hit_1, ex_hit_2, mem_hit_1, mem_hit_2, load_use, enter_ex;
  assign ex_hit_1 = hz.id_rs_read && ex_v && ex_wb && ex_reg == hz.id_rs && hz.id_rs != '0;
  assign ex_hit_2 = hz.id_rt_read && ex_v && ex_wb && ex_reg == hz.id_rt && hz.id_rt != '0;
  assign mem_hit_1 = hz.id_rs_read && mem_v && mem_wb && mem_reg == hz.id_rs && hz.id_rs != '0;
  assign mem_hit_2 = hz.id_rt_read && mem_v && mem_wb && mem_reg == hz.id_rt && hz.id_rt != '0;
  assign load_use = hz.id_valid && ex_v && ex_load && (ex_hit_1 || ex_hit_2);
  assign hz.fwd_sel_1 = fwd_pick(ex_hit_1, mem_hit_1);
  assign hz.fwd_sel_2 = fwd_pick(ex_hit_2, mem_hit_2);
  assign hz.stall_front = !hz.flush && (hz.mem_stall_req || busy || load_use);
  assign hz.stall_back = !hz.flush && hz.mem_stall_req;
  assign hz.bubble_ex = !hz.flush && !hz.mem_stall_req && !busy && load_use;
  assign hz.mc_busy = !hz.flush && busy;
  assign enter_ex = !hz.flush && !hz.mem_stall_req && !busy && hz.id_valid && !load_use;
  // in-flight destination trackers; a busy multi-cycle op pins EX and feeds bubbles to MEM
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v <= 1'b0;
      ex_wb <= 1'b0;
      ex_load <= 1'b0;
      ex_reg <= '0;
      mem_v <= 1'b0;
      mem_wb <= 1'b0;
      mem_reg <= '0;
    end else if (hz.flush) begin
      ex_v <= 1'b0;
      mem_v <= 1'b0;
    end else if (!hz.stall_back) begin
      mem_v <= ex_v && !busy;
      mem_wb <= ex_wb;
      mem_reg <= ex_reg;
      if (!busy) begin
        ex_v <= enter_ex;
        ex_wb <= hz.id_wb_en;
        ex_load <= hz.id_is_load;
        ex_reg <= hz.id_wb_reg;
      end
    end
  end
  operand_hazard_ctrl_mc_stall_timer #(.CYCLES(MC_CYCLES)) u_mc_stall_timer (
    .clk(clk),
    .rst(rst),
    .start(enter_ex && hz.id_multi_cycle),
    .pause(hz.mem_stall_req),
    .abort(hz.flush),
    .busy(busy)
  );
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_cnt;
  // saturating count of front-end stall cycles
  always_ff @(posedge clk) begin
    if (rst) perf_cnt <= '0;
    else if (hz.stall_front && perf_cnt != '1) perf_cnt <= perf_cnt + 1'b1;
  end
  assign hz.perf_stall_cnt = perf_cnt;
`else
  assign hz.perf_stall_cnt = PERF_W'(0);
`endif
endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// tb_operand_hazard_ctrl: directed and random checks against a pipeline-slot model (HAZARD_PERF_EN aware)
module tb_operand_hazard_ctrl;
  localparam int RW = 5, MCC = 4, PW = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif
  typedef struct packed {logic v; logic wb; logic ld; logic [RW-1:0] r;} slot_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  slot_t m_ex, m_mem;
  int mc_left, m_perf;
  operand_hazard_ctrl_if #(.REG_ADDR_W(RW), .PERF_W(PW)) bus();
  operand_hazard_ctrl #(.REG_ADDR_W(RW), .MC_CYCLES(MCC), .PERF_W(PW)) dut (.clk(clk), .rst(rst), .hz(bus));
  always #5 clk = ~clk;

  function automatic logic hit(input slot_t s, input logic rd, input logic [RW-1:0] r);
    return rd && s.v && s.wb && s.r == r && r != '0;
  endfunction
  function automatic logic [1:0] pick(input logic rd, input logic [RW-1:0] r);
    return hit(m_ex, rd, r) ? 2'd1 : hit(m_mem, rd, r) ? 2'd2 : 2'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rsr, input logic [RW-1:0] rs, input logic rtr,
                       input logic [RW-1:0] rt, input logic wb, input logic [RW-1:0] wr, input logic ld,
                       input logic mc, input logic msr, input logic fl);
    bus.id_valid = v;
    bus.id_rs_read = rsr;
    bus.id_rs = rs;
    bus.id_rt_read = rtr;
    bus.id_rt = rt;
    bus.id_wb_en = wb;
    bus.id_wb_reg = wr;
    bus.id_is_load = ld;
    bus.id_multi_cycle = mc;
    bus.mem_stall_req = msr;
    bus.flush = fl;
    #2;
  endtask

  task automatic step(input string tag);
    logic busy, lu, sf;
    busy = mc_left > 0;
    lu = bus.id_valid && m_ex.v && m_ex.ld &&
         (hit(m_ex, bus.id_rs_read, bus.id_rs) || hit(m_ex, bus.id_rt_read, bus.id_rt));
    sf = !bus.flush && (bus.mem_stall_req || busy || lu);
    chk({tag, ".stall_front"}, bus.stall_front, sf);
    chk({tag, ".stall_back"}, bus.stall_back, !bus.flush && bus.mem_stall_req);
    chk({tag, ".bubble_ex"}, bus.bubble_ex, !bus.flush && !bus.mem_stall_req && !busy && lu);
    chk({tag, ".mc_busy"}, bus.mc_busy, !bus.flush && busy);
    chk({tag, ".fwd_sel_1"}, bus.fwd_sel_1, pick(bus.id_rs_read, bus.id_rs));
    chk({tag, ".fwd_sel_2"}, bus.fwd_sel_2, pick(bus.id_rt_read, bus.id_rt));
    chk({tag, ".perf"}, bus.perf_stall_cnt, PERF_ON ? m_perf : 0);
    if (bus.flush) begin
      m_ex.v = 1'b0;
      m_mem.v = 1'b0;
      mc_left = 0;
    end else if (!bus.mem_stall_req) begin
      if (busy) begin
        m_mem.v = 1'b0;
        mc_left--;
      end else begin
        m_mem = m_ex;
        m_ex = '{v: bus.id_valid && !lu, wb: bus.id_wb_en, ld: bus.id_is_load, r: bus.id_wb_reg};
        if (m_ex.v && bus.id_multi_cycle) mc_left = MCC - 1;
      end
    end
    if (sf) m_perf++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ex = '0;
    m_mem = '0;
    mc_left = 0;
    m_perf = 0;
  endtask

  initial begin
    int nb, nf, ns;
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.stall_front", bus.stall_front, 0);
    chk("reset.stall_back", bus.stall_back, 0);
    chk("reset.bubble_ex", bus.bubble_ex, 0);
    chk("reset.mc_busy", bus.mc_busy, 0);
    chk("reset.fwd", {bus.fwd_sel_1, bus.fwd_sel_2}, 0);
    chk("reset.perf", bus.perf_stall_cnt, 0);
    step("reset");
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step("t1.wr3");
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1.fwd_ex", bus.fwd_sel_1, 2'b01);
    step("t1.rd3");
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
    step("t2.lw");
    drive(1, 0, 0, 1, 5, 1, 9, 0, 0, 0, 0);
    chk("t2.lu_stall", bus.stall_front, 1);
    chk("t2.lu_bubble", bus.bubble_ex, 1);
    step("t2.lu");
    drive(1, 0, 0, 1, 5, 1, 9, 0, 0, 0, 0);
    chk("t2.lu_release", bus.stall_front, 0);
    chk("t2.fwd_mem", bus.fwd_sel_2, 2'b10);
    step("t2.fwd");
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    step("t3.wr7a");
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    step("t3.wr7b");
    drive(1, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("t3.ex_prio_1", bus.fwd_sel_1, 2'b01);
    chk("t3.ex_prio_2", bus.fwd_sel_2, 2'b01);
    step("t3.rd7");
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("t3.wr0");
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3.r0_nofwd", bus.fwd_sel_1, 2'b00);
    step("t3.rd0");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("t4.mult");
    nb = 0;
    repeat (8) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (bus.mc_busy) nb++;
      step("t4.run");
    end
    chk("t4.mc_len", nb, 3);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("t4.mult2");
    nf = 0;
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, i == 1 || i == 2, 0);
      if (i == 2) chk("t4.busy_in_memstall", bus.mc_busy, 1);
      if (bus.stall_front) nf++;
      if (bus.stall_back) ns++;
      step("t4.memstall");
    end
    chk("t4.stall_len", nf, 5);
    chk("t4.back_len", ns, 2);
    drive(1, 0, 0, 0, 0, 1, 4, 0, 1, 0, 0);
    step("t5.mult");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t5.flush_sf", bus.stall_front, 0);
    chk("t5.flush_sb", bus.stall_back, 0);
    chk("t5.flush_bub", bus.bubble_ex, 0);
    chk("t5.flush_mc", bus.mc_busy, 0);
    step("t5.flush");
    drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5.cleared_fwd", bus.fwd_sel_1, 2'b00);
    chk("t5.cleared_mc", bus.mc_busy, 0);
    step("t5.after");
    drive(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0);
    step("t6.lw");
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("t6.flush_sf", bus.stall_front, 0);
    chk("t6.flush_bub", bus.bubble_ex, 0);
    step("t6.flush");
    drive(1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t6.cleared_fwd", bus.fwd_sel_1, 2'b00);
    chk("t6.cleared_sf", bus.stall_front, 0);
    step("t6.after");
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
    step("t7.lw");
    drive(1, 1, 5, 0, 0, 1, 9, 0, 0, 0, 0);
    step("t7.lu");
    drive(1, 1, 5, 0, 0, 1, 9, 0, 0, 0, 0);
    step("t7.addu");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step("t7.mult");
    repeat (5) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("t7.run");
    end
    chk("t7.perf_total", bus.perf_stall_cnt, PERF_ON ? 4 : 0);
    repeat (400) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, RW'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, RW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            RW'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 31) == 0);
      step("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
